// File: rtl/firebird7_in_gate1_tessent_sib_spare_green.sv
// Multi-segment SIB host: one segment-insertion bit per client, splicing each
// client's scan segment into the IJTAG path while its SIB is open.

module firebird7_in_gate1_tessent_sib_spare_green_cell (
    input  logic ijtag_tck,
    input  logic ijtag_reset,
    input  logic ijtag_sel,
    input  logic ijtag_ce,
    input  logic ijtag_se,
    input  logic ijtag_ue,
    input  logic seg_si,
    input  logic seg_so,
    output logic sib,
    output logic upd
);
    logic shift_in;

    // An open SIB takes its shift bit from the end of its client segment.
    assign shift_in = upd ? seg_so : seg_si;

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            sib <= 1'b0;
        end else if (ijtag_sel) begin
            if (ijtag_ce)      sib <= upd;
            else if (ijtag_se) sib <= shift_in;
        end
    end

    always_ff @(negedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset)                  upd <= 1'b0;
        else if (ijtag_sel && ijtag_ue)   upd <= sib;
    end
endmodule

module firebird7_in_gate1_tessent_sib_spare_green #(
    parameter int unsigned N_CLIENTS = 2
) (
    input  logic                 ijtag_tck,
    input  logic                 ijtag_reset,
    input  logic                 ijtag_sel,
    input  logic                 ijtag_si,
    input  logic                 ijtag_ce,
    input  logic                 ijtag_se,
    input  logic                 ijtag_ue,
    output logic                 ijtag_so,
    output logic [N_CLIENTS-1:0] ijtag_to_sel,
    output logic [N_CLIENTS-1:0] ijtag_to_si,
    input  logic [N_CLIENTS-1:0] ijtag_from_so,
    output logic                 ijtag_to_ce,
    output logic                 ijtag_to_se,
    output logic                 ijtag_to_ue
);
    logic [N_CLIENTS-1:0] sib;
    logic [N_CLIENTS-1:0] upd;
    logic                 so_q;

    assign ijtag_to_si[0] = ijtag_si;
    for (genvar i = 1; i < N_CLIENTS; i++) begin : g_chain
        assign ijtag_to_si[i] = sib[i-1];
    end

    firebird7_in_gate1_tessent_sib_spare_green_cell u_sib [N_CLIENTS-1:0] (
        .ijtag_tck   (ijtag_tck),
        .ijtag_reset (ijtag_reset),
        .ijtag_sel   (ijtag_sel),
        .ijtag_ce    (ijtag_ce),
        .ijtag_se    (ijtag_se),
        .ijtag_ue    (ijtag_ue),
        .seg_si      (ijtag_to_si),
        .seg_so      (ijtag_from_so),
        .sib         (sib),
        .upd         (upd)
    );

    assign ijtag_to_sel = {N_CLIENTS{ijtag_sel}} & upd;
    assign ijtag_to_ce  = ijtag_ce;
    assign ijtag_to_se  = ijtag_se;
    assign ijtag_to_ue  = ijtag_ue;

    // Half-cycle retime so the parent samples a stable bit on its rising edge.
    always_latch begin
        if (ijtag_reset)     so_q <= 1'b0;
        else if (!ijtag_tck) so_q <= sib[N_CLIENTS-1];
    end

    assign ijtag_so = so_q;
endmodule

// File: tb/tb_firebird7_in_gate1_tessent_sib_spare_green.sv
// Bench for the SIB host with an 8-bit and a 4-bit client TDR attached.
module tb_firebird7_in_gate1_tessent_sib_spare_green;
    localparam logic [3:0] C1_CAP = 4'h5;

    logic       tck, rst, sel, si, ce, se, ue;
    logic       so, to_ce, to_se, to_ue;
    logic [1:0] to_sel, to_si, from_so;

    // Client TDRs (environment): si enters the MSB, scan-out is the LSB.
    logic [7:0] c0 = 8'h3C;
    logic [3:0] c1 = 4'h9;

    // Reference model state.
    logic [1:0] m_sib, m_upd;
    logic [7:0] m_c0;
    logic [3:0] m_c1;

    int n_cmp = 0;
    int n_err = 0;

    firebird7_in_gate1_tessent_sib_spare_green #(.N_CLIENTS(2)) dut (
        .ijtag_tck     (tck),
        .ijtag_reset   (rst),
        .ijtag_sel     (sel),
        .ijtag_si      (si),
        .ijtag_ce      (ce),
        .ijtag_se      (se),
        .ijtag_ue      (ue),
        .ijtag_so      (so),
        .ijtag_to_sel  (to_sel),
        .ijtag_to_si   (to_si),
        .ijtag_from_so (from_so),
        .ijtag_to_ce   (to_ce),
        .ijtag_to_se   (to_se),
        .ijtag_to_ue   (to_ue)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    assign from_so = {c1[0], c0[0]};

    always @(posedge tck) begin
        if (to_sel[0]) begin
            if (to_ce)      c0 <= 8'h00;
            else if (to_se) c0 <= {to_si[0], c0[7:1]};
        end
        if (to_sel[1]) begin
            if (to_ce)      c1 <= C1_CAP;
            else if (to_se) c1 <= {to_si[1], c1[3:1]};
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scan path as a flat bit list, index 0 nearest ijtag_si.
    task automatic m_pos(input logic s, input logic c, input logic e, input logic d);
        logic q[$];
        if (!s) return;
        if (c) begin
            m_sib = m_upd;
            if (m_upd[0]) m_c0 = 8'h00;
            if (m_upd[1]) m_c1 = C1_CAP;
        end else if (e) begin
            q.delete();
            if (m_upd[0]) for (int b = 7; b >= 0; b--) q.push_back(m_c0[b]);
            q.push_back(m_sib[0]);
            if (m_upd[1]) for (int b = 3; b >= 0; b--) q.push_back(m_c1[b]);
            q.push_back(m_sib[1]);
            q.push_front(d);
            void'(q.pop_back());
            if (m_upd[0]) for (int b = 7; b >= 0; b--) m_c0[b] = q.pop_front();
            m_sib[0] = q.pop_front();
            if (m_upd[1]) for (int b = 3; b >= 0; b--) m_c1[b] = q.pop_front();
            m_sib[1] = q.pop_front();
        end
    endtask

    task automatic check_all();
        chk("to_sel", {6'd0, to_sel}, {6'd0, {2{sel}} & m_upd});
        chk("so",     {7'd0, so},     {7'd0, m_sib[1]});
        chk("to_si",  {6'd0, to_si},  {6'd0, m_sib[0], si});
        chk("c0",     c0,             m_c0);
        chk("c1",     {4'd0, c1},     {4'd0, m_c1});
        chk("bcast",  {5'd0, to_ce, to_se, to_ue}, {5'd0, ce, se, ue});
    endtask

    // Inputs set while TCK is low; rising edge shifts/captures, falling edge updates.
    task automatic step(input logic s, input logic c, input logic e, input logic u, input logic d);
        sel = s; ce = c; se = e; ue = u; si = d;
        @(posedge tck); m_pos(s, c, e, d);
        @(negedge tck); if (s && u) m_upd = m_sib;
        #1; check_all();
    endtask

    initial begin
        m_c0 = 8'h3C; m_c1 = 4'h9;
        m_sib = '0; m_upd = '0;
        rst = 1'b1; sel = 0; si = 0; ce = 0; se = 0; ue = 0;
        repeat (2) @(negedge tck);
        #1;
        check_all();
        rst = 1'b0;

        // Open both clients: shift 1,1 then update.
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0);
        chk("open_both", {6'd0, to_sel}, 8'h03);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 1'($urandom));

        // Reset asserted while TCK is high during a shift.
        sel = 1; ce = 0; se = 1; ue = 0; si = 1;
        @(posedge tck); m_pos(1, 0, 1, 1);
        #2 rst = 1'b1;
        m_sib = '0; m_upd = '0;
        #1 chk("rst_to_sel", {6'd0, to_sel}, 8'h00);
        @(negedge tck); #1 chk("rst_so", {7'd0, so}, 8'h00);
        @(posedge tck); @(negedge tck); #1;
        check_all();
        rst = 1'b0;

        // Capture, shift 0 then 1, update: only client 0 opens.
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0);
        chk("open_c0", {6'd0, to_sel}, 8'h01);

        // Capture then ten shifts of ones through the 10-bit chain.
        step(1, 1, 0, 0, 0);
        chk("cap_so", {7'd0, so}, 8'h00);
        for (int k = 0; k < 10; k++) step(1, 0, 1, 0, 1);
        chk("c0_ones", c0, 8'hFF);

        // Deselected: nothing moves regardless of ce/se/ue.
        for (int k = 0; k < 20; k++) begin
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("desel_to_sel", {6'd0, to_sel}, 8'h00);
        end

        // ce and se together: capture wins.
        step(1, 1, 1, 0, 1);

        // Place 0 in sib0 and 1 in sib1, then update: only client 1 opens.
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++) step(1, 0, 1, 0, 1'($urandom));
        step(1, 0, 0, 1, 0);
        chk("open_c1", {6'd0, to_sel}, 8'h02);
        for (int k = 0; k < 6; k++) step(1, 0, 1, 0, 1'($urandom));

        // Randomized traffic against the model.
        for (int k = 0; k < 300; k++)
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
                 1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
